// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
// Optional BP_STATS_EN builds the hit-lookup and mispredict counters.
module branch_predictor #(
    parameter int PC_WIDTH = 32,
    parameter int ENTRIES  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [PC_WIDTH-1:0] PCF_i,
    output logic                predictTakenF_o,
    output logic [PC_WIDTH-1:0] PCTargetPredF_o,
    input  logic                updateE_i,
    input  logic [PC_WIDTH-1:0] PCE_i,
    input  logic                branchTakenE_i,
    input  logic [PC_WIDTH-1:0] PCTargetE_i,
    input  logic                predictTakenE_i,
    output logic [31:0]         lookupCountO_o,
    output logic [31:0]         mispredictCount_o
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX_W - 2;

    logic [ENTRIES-1:0]  r_valid;
    logic [TAG_W-1:0]    r_tag [ENTRIES];
    logic [PC_WIDTH-1:0] r_tgt [ENTRIES];
    logic [1:0]          r_ctr [ENTRIES];

    logic [IDX_W-1:0] w_fidx, w_eidx;
    logic [TAG_W-1:0] w_ftag, w_etag;
    logic             w_fhit, w_ehit;
    logic [1:0]       w_ectr;

    assign w_fidx = PCF_i[IDX_W+1:2];
    assign w_ftag = PCF_i[PC_WIDTH-1:IDX_W+2];
    assign w_eidx = PCE_i[IDX_W+1:2];
    assign w_etag = PCE_i[PC_WIDTH-1:IDX_W+2];
    assign w_fhit = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
    assign w_ehit = r_valid[w_eidx] && (r_tag[w_eidx] == w_etag);
    assign w_ectr = r_ctr[w_eidx];

    assign predictTakenF_o = w_fhit && r_ctr[w_fidx][1];
    assign PCTargetPredF_o = w_fhit ? r_tgt[w_fidx] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= 2'b01;
        end else if (updateE_i) begin
            if (w_ehit)
                r_ctr[w_eidx] <= branchTakenE_i ? (w_ectr == 2'b11 ? 2'b11 : w_ectr + 2'b01)
                                                : (w_ectr == 2'b00 ? 2'b00 : w_ectr - 2'b01);
            else if (branchTakenE_i) begin
                r_valid[w_eidx] <= 1'b1;
                r_ctr[w_eidx]   <= 2'b10;
            end
        end
    end

    // Tag rewrite on a hit stores the same value, so every taken update writes both fields.
    always_ff @(posedge clk_i) begin
        if (!rst_i && updateE_i && branchTakenE_i) begin
            r_tag[w_eidx] <= w_etag;
            r_tgt[w_eidx] <= PCTargetE_i;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_lkp_cnt, r_mis_cnt;
    logic        w_unused;

    assign w_unused          = ^{PCF_i[1:0], PCE_i[1:0]};
    assign lookupCountO_o    = r_lkp_cnt;
    assign mispredictCount_o = r_mis_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lkp_cnt <= '0;
            r_mis_cnt <= '0;
        end else begin
            if (w_fhit) r_lkp_cnt <= r_lkp_cnt + 32'd1;
            if (updateE_i && (predictTakenE_i != branchTakenE_i)) r_mis_cnt <= r_mis_cnt + 32'd1;
        end
    end
`else
    logic w_unused;

    assign w_unused          = ^{predictTakenE_i, PCF_i[1:0], PCE_i[1:0]};
    assign lookupCountO_o    = '0;
    assign mispredictCount_o = '0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of lookup, training, aliasing, reset and stats.
module tb_branch_predictor;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] PCF_i = '0;
    logic        predictTakenF_o;
    logic [31:0] PCTargetPredF_o;
    logic        updateE_i = 1'b0;
    logic [31:0] PCE_i = '0;
    logic        branchTakenE_i = 1'b0;
    logic [31:0] PCTargetE_i = '0;
    logic        predictTakenE_i = 1'b0;
    logic [31:0] lookupCountO_o, mispredictCount_o;

    int n_checks = 0;
    int n_errors = 0;

    branch_predictor dut (
        .clk_i(clk_i), .rst_i(rst_i), .PCF_i(PCF_i),
        .predictTakenF_o(predictTakenF_o), .PCTargetPredF_o(PCTargetPredF_o),
        .updateE_i(updateE_i), .PCE_i(PCE_i), .branchTakenE_i(branchTakenE_i),
        .PCTargetE_i(PCTargetE_i), .predictTakenE_i(predictTakenE_i),
        .lookupCountO_o(lookupCountO_o), .mispredictCount_o(mispredictCount_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", t, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic pr);
        updateE_i = 1'b1;
        PCE_i = pc;
        branchTakenE_i = tk;
        PCTargetE_i = tgt;
        predictTakenE_i = pr;
        tick();
        updateE_i = 1'b0;
    endtask

    task automatic look(input string t, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        PCF_i = pc;
        #1;
        chk({t, "_taken"}, {31'd0, predictTakenF_o}, {31'd0, tk});
        if (tk) chk({t, "_target"}, PCTargetPredF_o, tgt);
    endtask

    initial begin
        tick();
        chk("rst_taken", {31'd0, predictTakenF_o}, 32'd0);
        chk("rst_target", PCTargetPredF_o, 32'd0);
        tick();
        rst_i = 1'b0;
        look("cold", 32'h100, 1'b0, 32'h0);
        chk("cold_target0", PCTargetPredF_o, 32'd0);

        upd(32'h100, 1'b1, 32'h40, 1'b0);
        look("alloc", 32'h100, 1'b1, 32'h40);
        upd(32'h100, 1'b0, 32'h0, 1'b1);
        look("weak_nt", 32'h100, 1'b0, 32'h0);

        repeat (4) upd(32'h200, 1'b1, 32'h80, 1'b0);
        look("sat_t", 32'h200, 1'b1, 32'h80);
        upd(32'h200, 1'b0, 32'h0, 1'b1);
        look("nt1", 32'h200, 1'b1, 32'h80);
        upd(32'h200, 1'b0, 32'h0, 1'b1);
        look("nt2", 32'h200, 1'b0, 32'h0);
        repeat (3) upd(32'h200, 1'b0, 32'h0, 1'b0);
        upd(32'h200, 1'b1, 32'h84, 1'b0);
        look("sat_nt", 32'h200, 1'b0, 32'h0);
        upd(32'h200, 1'b1, 32'h88, 1'b0);
        look("retarget", 32'h200, 1'b1, 32'h88);

        upd(32'h100, 1'b1, 32'h40, 1'b0);
        look("alias_pre", 32'h100, 1'b1, 32'h40);
        upd(32'h140, 1'b1, 32'h20, 1'b0);
        look("alias_old", 32'h100, 1'b0, 32'h0);
        look("alias_new", 32'h140, 1'b1, 32'h20);

        upd(32'h504, 1'b0, 32'h99, 1'b0);
        look("nt_miss", 32'h504, 1'b0, 32'h0);
        chk("nt_miss_target", PCTargetPredF_o, 32'd0);

        PCF_i = 32'h300;
        updateE_i = 1'b1;
        PCE_i = 32'h300;
        branchTakenE_i = 1'b1;
        PCTargetE_i = 32'h60;
        #1;
        chk("same_cyc", {31'd0, predictTakenF_o}, 32'd0);
        tick();
        updateE_i = 1'b0;
        look("next_cyc", 32'h300, 1'b1, 32'h60);

`ifndef BP_STATS_EN
        chk("nostat_lookup", lookupCountO_o, 32'd0);
        chk("nostat_mispredict", mispredictCount_o, 32'd0);
`endif

        rst_i = 1'b1;
        updateE_i = 1'b1;
        PCE_i = 32'h608;
        branchTakenE_i = 1'b1;
        PCTargetE_i = 32'h77;
        tick();
        chk("in_rst_taken", {31'd0, predictTakenF_o}, 32'd0);
        chk("in_rst_target", PCTargetPredF_o, 32'd0);
        updateE_i = 1'b0;
        rst_i = 1'b0;
        look("rst_drop", 32'h608, 1'b0, 32'h0);
        look("rst_clear", 32'h300, 1'b0, 32'h0);

`ifdef BP_STATS_EN
        chk("stat_rst_mis", mispredictCount_o, 32'd0);
        PCF_i = 32'h700;
        repeat (3) upd(32'h704, 1'b0, 32'h0, 1'b1);
        upd(32'h704, 1'b0, 32'h0, 1'b0);
        chk("stat_lkp_miss", lookupCountO_o, 32'd0);
        upd(32'h700, 1'b1, 32'h10, 1'b1);
        tick();
        tick();
        chk("stat_mis", mispredictCount_o, 32'd3);
        chk("stat_lkp", lookupCountO_o, 32'd2);
        force dut.r_mis_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_mis_cnt;
        chk("stat_preload", mispredictCount_o, 32'hFFFF_FFFF);
        upd(32'h704, 1'b1, 32'h0, 1'b0);
        chk("stat_wrap", mispredictCount_o, 32'd0);
`else
        upd(32'h704, 1'b1, 32'h0, 1'b0);
        chk("nostat_lookup_end", lookupCountO_o, 32'd0);
        chk("nostat_mispredict_end", mispredictCount_o, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage dynamic branch predictor: a direct-mapped branch target buffer with a 2-bit saturating counter per entry. It produces `predictTakenF_o` and the predicted target consumed by the F/D pipeline register and the PC-next mux. It is trained by branch resolution results from the Execute stage. The block sits between the Fetch PC register and the Execute-stage branch comparator; it is the producer side of the `predictTaken` signal that the pipeline carries down to Execute.

## Interface
- `PC_WIDTH`, 32, PC / target width in bits
- `ENTRIES`, 16, BTB entry count; power of two, ≥2; `IDX_W = $clog2(ENTRIES)`, `TAG_W = PC_WIDTH-IDX_W-2`

- `clk_i` in 1: single clock, all state updates on posedge
- `rst_i` in 1: reset, synchronous, active-high
- `PCF_i` in PC_WIDTH: Fetch PC (lookup address)
- `predictTakenF_o` out 1: prediction for `PCF_i`
- `PCTargetPredF_o` out PC_WIDTH: predicted target; meaningful only when `predictTakenF_o`=1
- `updateE_i` in 1: a conditional branch resolved in Execute this cycle
- `PCE_i` in PC_WIDTH: PC of the resolving branch
- `branchTakenE_i` in 1: actual outcome
- `PCTargetE_i` in PC_WIDTH: actual taken target
- `predictTakenE_i` in 1: prediction carried down the pipe for this branch (used for statistics only)
- `lookupCountO_o` out 32: Fetch lookups with hit (`BP_STATS_EN` only)
- `mispredictCount_o` out 32: mispredicted branches (`BP_STATS_EN` only)

## Operation
- Entry fields: `valid`, `tag[TAG_W]`, `target[PC_WIDTH]`, `ctr[2]` (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
- Index = `PC[IDX_W+1:2]`; tag = `PC[PC_WIDTH-1:IDX_W+2]`; `PC[1:0]` is ignored.
- Lookup is combinational: hit = `valid && tag==PCF_i tag`; `predictTakenF_o = hit && ctr[1]`; `PCTargetPredF_o` = entry target on hit, else 0.
- Update applies on the posedge where `updateE_i`=1:
  - Hit at `PCE_i`, taken: `ctr` increments, saturating at 11; target is overwritten with `PCTargetE_i`.
  - Hit, not taken: `ctr` decrements, saturating at 00; target is unchanged.
  - Miss, taken: allocate (overwrite any resident entry) with valid=1, new tag, target=`PCTargetE_i`, ctr=10.
  - Miss, not taken: no change; no allocation.
- `updateE_i`=0: no table change. Inputs other than `updateE_i` are don't-care.
- The block has no stall/flush inputs. A flushed Fetch simply discards the prediction, and Execute asserts `updateE_i` only for valid, non-bubble branches.

## Timing
- Lookup latency is 0 cycles, combinational from `PCF_i`.
- An update becomes visible to lookups in the cycle after the update edge.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update entry; there is no bypass.
- Reset (`rst_i`=1 at a posedge): all `valid` cleared, all `ctr` set to 01, stats counters cleared to 0.
  - While `rst_i` is held, `predictTakenF_o`=0 and `PCTargetPredF_o`=0 from the first reset edge onward.
  - Reset has priority over a coincident update; the update is dropped.
- Tags and targets are not reset. They are only observable through valid entries.

## Configuration
- `BP_STATS_EN` defined:
  - `lookupCountO_o` increments on every posedge where a Fetch lookup hits and `rst_i`=0.
  - `mispredictCount_o` increments on every posedge where `updateE_i`=1 and `predictTakenE_i != branchTakenE_i`.
  - Both counters are 32-bit, wrap modulo 2^32, and reset to 0.
- `BP_STATS_EN` undefined: both outputs are tied to 0, no counter flops are built, and `predictTakenE_i` is unused.

## Test plan
- Reset, then look up `PCF_i`=0x100 → `predictTakenF_o`=0, `PCTargetPredF_o`=0.
- Update PC=0x100, taken, target=0x40, then look up 0x100 next cycle → taken=1, target=0x40 (ctr=10).
  - Follow with one not-taken update → taken=0 (ctr=01).
- Four taken updates at 0x200 (target 0x80), then five not-taken updates → ctr saturates at 11 then 00; prediction flips to 0 after the 2nd not-taken update.
- ENTRIES=16: train 0x100 taken, then train 0x140 (same index, different tag) taken to target 0x20 → lookup 0x100 misses (taken=0), lookup 0x140 gives taken=1, target=0x20.
  - A not-taken miss update at a fresh PC leaves the entry invalid.
- Lookup 0x300 in the same cycle as the first taken update to 0x300 → taken=0 that cycle, 1 the next.
  - Assert `rst_i` together with an update → the entry stays invalid.
- With `BP_STATS_EN`: 3 updates with `predictTakenE_i` ≠ `branchTakenE_i` plus 2 matching updates → `mispredictCount_o`=3.
  - Preload `mispredictCount_o`=0xFFFFFFFF, then one mispredict → 0.
  - Without the macro, both stats outputs stay 0.
